cordic_lut_sequencer: RTL
=========================

Name: cordic_lut_sequencer

Overview:
- Iteration controller for the natural-logarithm CORDIC datapath.
- Walks the LUT_SHIFT ROM address space once per operation and enables the ROM only while fetching.
- Latches each iteration's shift amount and hands it to the datapath with a valid/ack handshake.
- Sits between the top-level operation FSM (START/DONE) and the CORDIC add/shift stage; LUT_SHIFT is a registered ROM with one-cycle read latency.

Parameters:
- ROM_WIDTH, 5, width of LUT_SHIFT data (O_D) and of SHIFT_AMT.
- ADRS_WIDTH, 5, width of ROM address.
- N_ITER, 26, iterations per operation; legal range 1..2**ADRS_WIDTH.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- START  in  1  begin operation; sampled only in IDLE.
- ITER_ACK  in  1  datapath has consumed current SHIFT_AMT.
- ROM_DATA  in  ROM_WIDTH  LUT_SHIFT O_D.
- EN_ROM1  out  1  LUT_SHIFT enable.
- ADRS  out  ADRS_WIDTH  LUT_SHIFT address = current iteration index.
- SHIFT_AMT  out  ROM_WIDTH  latched shift amount for current iteration.
- ITER_IDX  out  ADRS_WIDTH  index of iteration presented on SHIFT_AMT.
- ITER_VALID  out  1  SHIFT_AMT/ITER_IDX valid; held until ITER_ACK.
- LAST_ITER  out  1  high with ITER_VALID when ITER_IDX == N_ITER-1.
- BUSY  out  1  high in any state except IDLE.
- DONE  out  1  one-cycle pulse after last iteration acknowledged.

Behaviour:
- Reset: all outputs registered and 0; state IDLE, iteration counter 0. RST has priority over every input, in every state, including mid-operation (ITER_VALID drops the cycle after RST).
- States: IDLE, FETCH, CAPTURE, PRESENT, FINISH.
- IDLE: EN_ROM1=0, BUSY=0.
  - START=1 -> FETCH, counter cleared to 0.
- FETCH: EN_ROM1=1, ADRS=counter (one cycle).
  - Next cycle -> CAPTURE.
- CAPTURE: EN_ROM1=0, ADRS held.
  - At the end of this cycle, SHIFT_AMT<=ROM_DATA and ITER_IDX<=counter.
  - Next cycle -> PRESENT.
- PRESENT: ITER_VALID=1; LAST_ITER=(counter==N_ITER-1); SHIFT_AMT and ITER_IDX stable.
  - No ITER_ACK: stay.
  - ITER_ACK and counter<N_ITER-1: counter+1, -> FETCH.
  - ITER_ACK and counter==N_ITER-1: -> FINISH.
- FINISH: DONE=1 for exactly one cycle, BUSY=1; -> IDLE.
- Latency:
  - START sampled at edge 0 -> FETCH visible cycle 1 -> CAPTURE cycle 2 -> ITER_VALID first high cycle 3.
  - ACK to next ITER_VALID: 3 cycles.
  - Minimum operation with ACK tied high: 3*N_ITER+1 cycles from START to DONE.
- Handshake:
  - ITER_ACK is sampled only in PRESENT and ignored elsewhere.
  - ACK may already be high when ITER_VALID rises; it is accepted that cycle.
- START while BUSY is ignored (not queued). START held high through FINISH restarts on the cycle after return to IDLE.
- Counter never exceeds N_ITER-1; no wrap inside an operation. For N_ITER=2**ADRS_WIDTH the last address is all ones.
- N_ITER=1: single FETCH/CAPTURE/PRESENT with LAST_ITER=1, then FINISH.
- ROM data is captured only in CAPTURE; ROM_DATA changes at other times have no effect on SHIFT_AMT.

Test Plan:
- Reset/idle: RST=1 for 3 cycles, then START=0 for 5 cycles -> all outputs 0, EN_ROM1 never asserted.
- Nominal run: bench ROM model O_D = ADRS ^ 5'h15 (registered, 1-cycle latency), ITER_ACK tied 1, N_ITER=26, pulse START.
  - First ITER_VALID 3 cycles after START, ITER_IDX=0, SHIFT_AMT=5'h15.
  - ITER_IDX=6 -> 5'h13; 7 -> 5'h12; 8 -> 5'h1D.
  - LAST_ITER only at ITER_IDX=25 (SHIFT_AMT=5'h0C).
  - DONE pulse at cycle 79 after START; 26 EN_ROM1 pulses total.
- Backpressure: ITER_ACK withheld for 7 cycles at ITER_IDX=3 -> ITER_VALID, SHIFT_AMT=5'h16 and ITER_IDX=3 held stable all 7 cycles, EN_ROM1=0 throughout; next FETCH 1 cycle after ACK.
- START while busy: pulse START again at ITER_IDX=10 -> ignored, counter continues, exactly one DONE. START held high through FINISH -> new FETCH with ADRS=0 two cycles after DONE.
- Reset mid-operation: RST at ITER_IDX=12 in PRESENT -> next cycle ITER_VALID=0, BUSY=0, ADRS=0, no DONE; a subsequent START restarts at ITER_IDX=0.
- Edge config: N_ITER=1 with ACK=1 -> single ITER_VALID with LAST_ITER=1, DONE 4 cycles after START. N_ITER=32 -> ADRS reaches 5'b11111, then DONE, no wrap to 0.

Source files
------------

// File: rtl/cordic_lut_sequencer.sv
// ============================================================================
// Module   : cordic_lut_sequencer
// Function : Iteration controller for the ln() CORDIC datapath. It walks the
//            LUT_SHIFT ROM and hands each shift amount over via valid/ack.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_lut_sequencer #(
    parameter int ROM_WIDTH  = 5,
    parameter int ADRS_WIDTH = 5,
    parameter int N_ITER     = 26
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  ITER_ACK,
    input  logic [ROM_WIDTH-1:0]  ROM_DATA,
    output logic                  EN_ROM1,
    output logic [ADRS_WIDTH-1:0] ADRS,
    output logic [ROM_WIDTH-1:0]  SHIFT_AMT,
    output logic [ADRS_WIDTH-1:0] ITER_IDX,
    output logic                  ITER_VALID,
    output logic                  LAST_ITER,
    output logic                  BUSY,
    output logic                  DONE
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_CAPTURE = 3'd2,
        S_PRESENT = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    localparam logic [ADRS_WIDTH-1:0] c_last_idx = ADRS_WIDTH'(N_ITER - 1);
    localparam logic [ADRS_WIDTH-1:0] c_one      = ADRS_WIDTH'(1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADRS_WIDTH-1:0] r_cnt;
    logic [ADRS_WIDTH-1:0] w_cnt_nxt;

    logic                  r_en_rom;
    logic [ROM_WIDTH-1:0]  r_shift_amt;
    logic [ADRS_WIDTH-1:0] r_iter_idx;
    logic                  r_iter_valid;
    logic                  r_last_iter;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_en_rom_nxt;
    logic                  w_iter_valid_nxt;
    logic                  w_last_iter_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;

    // Next state and counter; the counter only advances on an accepted
    // non-final iteration, so it can never pass c_last_idx.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_state_nxt = S_FETCH;
                    w_cnt_nxt   = '0;
                end
            end
            S_FETCH:   w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_PRESENT;
            S_PRESENT: begin
                if (ITER_ACK) begin
                    if (r_cnt == c_last_idx) begin
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_state_nxt = S_FETCH;
                        w_cnt_nxt   = r_cnt + c_one;
                    end
                end
            end
            S_FINISH:  w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet
    // line up with the state they describe.
    always_comb begin
        w_en_rom_nxt     = (w_state_nxt == S_FETCH);
        w_iter_valid_nxt = (w_state_nxt == S_PRESENT);
        w_last_iter_nxt  = (w_state_nxt == S_PRESENT) && (w_cnt_nxt == c_last_idx);
        w_busy_nxt       = (w_state_nxt != S_IDLE);
        w_done_nxt       = (w_state_nxt == S_FINISH);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_en_rom     <= 1'b0;
            r_iter_valid <= 1'b0;
            r_last_iter  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_en_rom     <= w_en_rom_nxt;
            r_iter_valid <= w_iter_valid_nxt;
            r_last_iter  <= w_last_iter_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    // ROM output is valid during CAPTURE (one cycle after the enabled FETCH).
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_shift_amt <= '0;
            r_iter_idx  <= '0;
        end else if (r_state == S_CAPTURE) begin
            r_shift_amt <= ROM_DATA;
            r_iter_idx  <= r_cnt;
        end
    end

    assign EN_ROM1    = r_en_rom;
    assign ADRS       = r_cnt;
    assign SHIFT_AMT  = r_shift_amt;
    assign ITER_IDX   = r_iter_idx;
    assign ITER_VALID = r_iter_valid;
    assign LAST_ITER  = r_last_iter;
    assign BUSY       = r_busy;
    assign DONE       = r_done;

endmodule

`default_nettype wire
